// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bus bundle between a register-map master and axil_reg_slave.
// Clock and reset travel outside the bundle as plain ports.
interface axil_reg_slave_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]                      awprot;
    logic                            awvalid;
    logic                            awready;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                            wvalid;
    logic                            wready;
    logic [1:0]                      bresp;
    logic                            bvalid;
    logic                            bready;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr;
    logic [2:0]                      arprot;
    logic                            arvalid;
    logic                            arready;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                      rresp;
    logic                            rvalid;
    logic                            rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave register file: independent write/read FSMs, byte strobes, flat register view.
// Optional macro AXIL_REG_SLVERR_EN: out-of-range word indices get SLVERR instead of aliasing.
module axil_reg_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 4
) (
    input  logic                                 i_aclk,
    input  logic                                 i_areset,
    axil_reg_slave_if.slave                      s_axil,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] o_reg_q
);
    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int NBYTES = DW / 8;
    localparam int WORD_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wrState_t;
    typedef enum logic {R_IDLE, R_DATA} rdState_t;

    logic [DW-1:0] r_regs [NUM_REGS];

    wrState_t          r_wrState;
    wrState_t          w_wrStateNext;
    logic              r_awReady;
    logic              r_wReady;
    logic              r_bValid;
    logic [1:0]        r_bResp;
    logic              w_awReadyNext;
    logic              w_wReadyNext;
    logic              w_bValidNext;
    logic [1:0]        w_bRespNext;

    logic              r_awHeld;
    logic              r_wHeld;
    logic [WORD_W-1:0] r_awWord;
    logic [DW-1:0]     r_wData;
    logic [NBYTES-1:0] r_wStrb;

    logic              w_awFire;
    logic              w_wFire;
    logic              w_bFire;
    logic              w_awHave;
    logic              w_wHave;
    logic              w_commit;
    logic              w_cmtErr;
    logic [WORD_W-1:0] w_cmtWord;
    logic [IDX_W-1:0]  w_cmtIdx;
    logic [DW-1:0]     w_cmtData;
    logic [NBYTES-1:0] w_cmtStrb;

    rdState_t          r_rdState;
    rdState_t          w_rdStateNext;
    logic              r_arReady;
    logic              r_rValid;
    logic [DW-1:0]     r_rData;
    logic [1:0]        r_rResp;
    logic              w_arReadyNext;
    logic              w_rValidNext;
    logic [DW-1:0]     w_rDataNext;
    logic [1:0]        w_rRespNext;

    logic              w_arFire;
    logic              w_rFire;
    logic              w_rdErr;
    logic [WORD_W-1:0] w_rdWord;
    logic [IDX_W-1:0]  w_rdIdx;
    logic [DW-1:0]     w_rdData;

    logic              w_unusedBits;

    assign s_axil.awready = r_awReady;
    assign s_axil.wready  = r_wReady;
    assign s_axil.bvalid  = r_bValid;
    assign s_axil.bresp   = r_bResp;
    assign s_axil.arready = r_arReady;
    assign s_axil.rvalid  = r_rValid;
    assign s_axil.rdata   = r_rData;
    assign s_axil.rresp   = r_rResp;

    // A channel counts as present if it is already held or handshaking this cycle.
    assign w_awFire  = s_axil.awvalid & r_awReady;
    assign w_wFire   = s_axil.wvalid & r_wReady;
    assign w_bFire   = r_bValid & s_axil.bready;
    assign w_awHave  = r_awHeld | w_awFire;
    assign w_wHave   = r_wHeld | w_wFire;
    assign w_commit  = (r_wrState == W_IDLE) & w_awHave & w_wHave;
    assign w_cmtWord = w_awFire ? s_axil.awaddr[C_S_AXI_ADDR_WIDTH-1:2] : r_awWord;
    assign w_cmtData = w_wFire ? s_axil.wdata : r_wData;
    assign w_cmtStrb = w_wFire ? s_axil.wstrb : r_wStrb;
    assign w_cmtIdx  = w_cmtWord[IDX_W-1:0];

    assign w_arFire  = s_axil.arvalid & r_arReady;
    assign w_rFire   = r_rValid & s_axil.rready;
    assign w_rdWord  = s_axil.araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_rdIdx   = w_rdWord[IDX_W-1:0];

`ifdef AXIL_REG_SLVERR_EN
    assign w_cmtErr = (32'(w_cmtWord) >= 32'(NUM_REGS));
    assign w_rdErr  = (32'(w_rdWord) >= 32'(NUM_REGS));
`else
    assign w_cmtErr = 1'b0;
    assign w_rdErr  = 1'b0;
`endif

    // Register array reads before this edge's commit, so a same-cycle read sees the old value.
    assign w_rdData = w_rdErr ? '0 : r_regs[w_rdIdx];

    assign w_unusedBits = ^{s_axil.awprot, s_axil.arprot, s_axil.awaddr[1:0],
                            s_axil.araddr[1:0], w_cmtWord, w_rdWord};

    genvar k;
    generate
        for (k = 0; k < NUM_REGS; k++) begin : g_regQ
            assign o_reg_q[DW*k +: DW] = r_regs[k];
        end
    endgenerate

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit && !w_cmtErr) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (w_cmtStrb[b]) begin
                    r_regs[w_cmtIdx][8*b +: 8] <= w_cmtData[8*b +: 8];
                end
            end
        end
    end

    // Holding registers let AW and W arrive in any order; they empty as soon as the write commits.
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_awHeld <= 1'b0;
            r_wHeld  <= 1'b0;
            r_awWord <= '0;
            r_wData  <= '0;
            r_wStrb  <= '0;
        end else if (w_commit) begin
            r_awHeld <= 1'b0;
            r_wHeld  <= 1'b0;
        end else begin
            if (w_awFire) begin
                r_awHeld <= 1'b1;
                r_awWord <= s_axil.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_wFire) begin
                r_wHeld <= 1'b1;
                r_wData <= s_axil.wdata;
                r_wStrb <= s_axil.wstrb;
            end
        end
    end

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_wrState <= W_IDLE;
            r_awReady <= 1'b0;
            r_wReady  <= 1'b0;
            r_bValid  <= 1'b0;
            r_bResp   <= RESP_OKAY;
        end else begin
            r_wrState <= w_wrStateNext;
            r_awReady <= w_awReadyNext;
            r_wReady  <= w_wReadyNext;
            r_bValid  <= w_bValidNext;
            r_bResp   <= w_bRespNext;
        end
    end

    always_comb begin
        w_wrStateNext = r_wrState;
        case (r_wrState)
            W_IDLE:  if (w_commit) w_wrStateNext = W_RESP;
            W_RESP:  if (w_bFire)  w_wrStateNext = W_IDLE;
            default: w_wrStateNext = W_IDLE;
        endcase
    end

    // Readies are registered, so this computes what they must be in the next cycle.
    always_comb begin
        w_awReadyNext = 1'b0;
        w_wReadyNext  = 1'b0;
        w_bValidNext  = r_bValid;
        w_bRespNext   = r_bResp;
        case (r_wrState)
            W_IDLE: begin
                if (w_commit) begin
                    w_bValidNext = 1'b1;
                    w_bRespNext  = w_cmtErr ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    w_awReadyNext = ~w_awHave;
                    w_wReadyNext  = ~w_wHave;
                end
            end
            W_RESP: begin
                if (w_bFire) begin
                    w_bValidNext  = 1'b0;
                    w_bRespNext   = RESP_OKAY;
                    w_awReadyNext = 1'b1;
                    w_wReadyNext  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_rdState <= R_IDLE;
            r_arReady <= 1'b0;
            r_rValid  <= 1'b0;
            r_rData   <= '0;
            r_rResp   <= RESP_OKAY;
        end else begin
            r_rdState <= w_rdStateNext;
            r_arReady <= w_arReadyNext;
            r_rValid  <= w_rValidNext;
            r_rData   <= w_rDataNext;
            r_rResp   <= w_rRespNext;
        end
    end

    always_comb begin
        w_rdStateNext = r_rdState;
        case (r_rdState)
            R_IDLE:  if (w_arFire) w_rdStateNext = R_DATA;
            R_DATA:  if (w_rFire)  w_rdStateNext = R_IDLE;
            default: w_rdStateNext = R_IDLE;
        endcase
    end

    always_comb begin
        w_arReadyNext = 1'b0;
        w_rValidNext  = r_rValid;
        w_rDataNext   = r_rData;
        w_rRespNext   = r_rResp;
        case (r_rdState)
            R_IDLE: begin
                if (w_arFire) begin
                    w_rValidNext = 1'b1;
                    w_rDataNext  = w_rdData;
                    w_rRespNext  = w_rdErr ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    w_arReadyNext = 1'b1;
                end
            end
            R_DATA: begin
                if (w_rFire) begin
                    w_rValidNext  = 1'b0;
                    w_arReadyNext = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave with a transaction-level register model checked every cycle.
// Define AXIL_REG_SLVERR_EN for both RTL and bench to exercise the out-of-range error responses.
`timescale 1ns/1ps
module tb_axil_reg_slave;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NREG = 4;
    localparam int OP_WRITE = 0;
    localparam int OP_READ = 1;

    logic clk = 1'b0;
    logic areset = 1'b1;
    logic [NREG*DW-1:0] regQ;
    int checks = 0;
    int failures = 0;
    logic monitorOn = 1'b0;

    logic [31:0] lastRdata;
    logic [1:0] lastRresp;
    logic [1:0] lastBresp;

    logic [31:0] model [NREG];
    logic [AW-1:0] awQ [$];
    logic [31:0] wDataQ [$];
    logic [3:0] wStrbQ [$];
    logic [1:0] bExpQ [$];
    logic [33:0] rExpQ [$];
    logic prevBStall = 1'b0;
    logic prevRStall = 1'b0;
    logic [1:0] prevBresp;
    logic [1:0] prevRresp;
    logic [31:0] prevRdata;

    axil_reg_slave_if #(.C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW)) bus ();

    axil_reg_slave #(
        .C_S_AXI_DATA_WIDTH(DW),
        .C_S_AXI_ADDR_WIDTH(AW),
        .NUM_REGS(NREG)
    ) dut (
        .i_aclk(clk),
        .i_areset(areset),
        .s_axil(bus),
        .o_reg_q(regQ)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic addrErr(input logic [AW-1:0] a);
`ifdef AXIL_REG_SLVERR_EN
        return int'(a >> 2) >= NREG;
`else
        return (a === 'x);
`endif
    endfunction

    function automatic int addrIdx(input logic [AW-1:0] a);
        return int'(a >> 2) % NREG;
    endfunction

    function automatic logic [127:0] modelFlat();
        logic [127:0] f;
        for (int i = 0; i < NREG; i++) f[32*i +: 32] = model[i];
        return f;
    endfunction

    // Transaction-level model: sampled mid-way through the second half-cycle, when all bus values are settled.
    always @(negedge clk) begin
        #2;
        if (monitorOn) begin
            checkOutput("reg_q_vs_model", regQ, modelFlat());
            if (prevBStall) checkOutput("b_stable", {bus.bvalid, bus.bresp}, {1'b1, prevBresp});
            if (prevRStall) checkOutput("r_stable", {bus.rvalid, bus.rresp, bus.rdata}, {1'b1, prevRresp, prevRdata});
            if (areset) begin
                for (int i = 0; i < NREG; i++) model[i] = '0;
                awQ.delete(); wDataQ.delete(); wStrbQ.delete(); bExpQ.delete(); rExpQ.delete();
                prevBStall = 1'b0;
                prevRStall = 1'b0;
            end else begin
                if (bus.bvalid && bus.bready) begin
                    if (bExpQ.size() == 0) checkOutput("b_unexpected", 1, 0);
                    else checkOutput("bresp_model", bus.bresp, bExpQ.pop_front());
                end
                if (bus.rvalid && bus.rready) begin
                    if (rExpQ.size() == 0) checkOutput("r_unexpected", 1, 0);
                    else checkOutput("rdata_model", {bus.rresp, bus.rdata}, rExpQ.pop_front());
                end
                if (bus.arvalid && bus.arready) begin
                    if (addrErr(bus.araddr)) rExpQ.push_back({2'b10, 32'h0});
                    else rExpQ.push_back({2'b00, model[addrIdx(bus.araddr)]});
                end
                if (bus.awvalid && bus.awready) awQ.push_back(bus.awaddr);
                if (bus.wvalid && bus.wready) begin
                    wDataQ.push_back(bus.wdata);
                    wStrbQ.push_back(bus.wstrb);
                end
                while (awQ.size() > 0 && wDataQ.size() > 0) begin
                    logic [AW-1:0] a;
                    logic [31:0] d;
                    logic [3:0] s;
                    a = awQ.pop_front();
                    d = wDataQ.pop_front();
                    s = wStrbQ.pop_front();
                    if (addrErr(a)) begin
                        bExpQ.push_back(2'b10);
                    end else begin
                        for (int b = 0; b < 4; b++)
                            if (s[b]) model[addrIdx(a)][8*b +: 8] = d[8*b +: 8];
                        bExpQ.push_back(2'b00);
                    end
                end
                prevBStall = bus.bvalid && !bus.bready;
                prevBresp = bus.bresp;
                prevRStall = bus.rvalid && !bus.rready;
                prevRresp = bus.rresp;
                prevRdata = bus.rdata;
            end
        end
    end

    // One AXI transaction; respDelay < 0 leaves the response pending for the caller.
    task automatic applyStimulus(input int op, input logic [AW-1:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, input int wLead, input int respDelay);
        int cyc;
        logic aDone, dDone, fireA, fireD, fired;
        aDone = 1'b0;
        dDone = 1'b0;
        fired = 1'b0;
        cyc = 0;
        @(negedge clk);
        if (op == OP_WRITE) begin
            bus.awaddr = addr;
            bus.wdata = data;
            bus.wstrb = strb;
            while (!(aDone && dDone) && cyc < 50) begin
                bus.awvalid = !aDone && (cyc >= wLead);
                bus.wvalid = !dDone;
                fireA = bus.awvalid && bus.awready;
                fireD = bus.wvalid && bus.wready;
                @(negedge clk);
                if (fireA) aDone = 1'b1;
                if (fireD) dDone = 1'b1;
                cyc++;
                if (wLead > 0 && dDone && !aDone) begin
                    checkOutput("wready_gap", bus.wready, 0);
                    checkOutput("awready_gap", bus.awready, 1);
                end
            end
            bus.awvalid = 1'b0;
            bus.wvalid = 1'b0;
            checkOutput("aw_w_timeout", aDone && dDone, 1);
            checkOutput("bvalid_latency", bus.bvalid, 1);
            checkOutput("readies_in_resp", {bus.awready, bus.wready}, 2'b00);
            if (respDelay >= 0) begin
                cyc = 0;
                while (!fired && cyc < 50) begin
                    bus.bready = (cyc >= respDelay);
                    fireA = bus.bvalid && bus.bready;
                    if (!bus.bready) checkOutput("b_hold", {bus.bvalid, bus.awready, bus.wready}, 3'b100);
                    lastBresp = bus.bresp;
                    @(negedge clk);
                    if (fireA) fired = 1'b1;
                    cyc++;
                end
                bus.bready = 1'b0;
                checkOutput("b_timeout", fired, 1);
                checkOutput("ready_after_b", {bus.awready, bus.wready, bus.bvalid}, 3'b110);
            end
        end else begin
            bus.araddr = addr;
            while (!aDone && cyc < 50) begin
                bus.arvalid = 1'b1;
                fireA = bus.arready;
                @(negedge clk);
                if (fireA) aDone = 1'b1;
                cyc++;
            end
            bus.arvalid = 1'b0;
            checkOutput("ar_timeout", aDone, 1);
            checkOutput("rvalid_latency", {bus.rvalid, bus.arready}, 2'b10);
            if (respDelay >= 0) begin
                cyc = 0;
                while (!fired && cyc < 50) begin
                    bus.rready = (cyc >= respDelay);
                    fireA = bus.rvalid && bus.rready;
                    if (!bus.rready) checkOutput("r_hold", {bus.rvalid, bus.arready}, 2'b10);
                    lastRdata = bus.rdata;
                    lastRresp = bus.rresp;
                    @(negedge clk);
                    if (fireA) fired = 1'b1;
                    cyc++;
                end
                bus.rready = 1'b0;
                checkOutput("r_timeout", fired, 1);
                checkOutput("ready_after_r", {bus.arready, bus.rvalid}, 2'b10);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        for (int i = 0; i < NREG; i++) model[i] = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_readies", {bus.awready, bus.wready, bus.arready}, 3'b000);
        checkOutput("reset_valids", {bus.bvalid, bus.rvalid, bus.bresp, bus.rresp}, 6'b0);
        checkOutput("reset_rdata", bus.rdata, 0);
        checkOutput("reset_reg_q", regQ, 0);
        monitorOn = 1'b1;
        areset = 1'b0;
        @(negedge clk);
        checkOutput("readies_after_reset", {bus.awready, bus.wready, bus.arready}, 3'b111);

        // Sequential write and readback
        for (int i = 0; i < 4; i++) applyStimulus(OP_WRITE, AW'(4 * i), 32'(i + 1), 4'hF, 0, 0);
        checkOutput("seq_reg_q", regQ, 128'h00000004_00000003_00000002_00000001);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(OP_READ, AW'(4 * i), '0, '0, 0, 0);
            checkOutput("seq_rdata", {lastRresp, lastRdata}, {2'b00, 32'(i + 1)});
        end

        // Byte strobes
        applyStimulus(OP_WRITE, 5'h00, 32'hAABBCCDD, 4'hF, 0, 0);
        applyStimulus(OP_WRITE, 5'h00, 32'h11223344, 4'h5, 0, 0);
        checkOutput("strb_bresp", lastBresp, 2'b00);
        applyStimulus(OP_READ, 5'h00, '0, '0, 0, 0);
        checkOutput("strb_rdata", lastRdata, 32'hAA22CC44);

        // W leads AW by three cycles
        applyStimulus(OP_WRITE, 5'h08, 32'hDEADBEEF, 4'hF, 3, 0);
        checkOutput("order_reg2", regQ[95:64], 32'hDEADBEEF);

        // Backpressure on both responses
        applyStimulus(OP_WRITE, 5'h0C, 32'hCAFEF00D, 4'hF, 0, 5);
        applyStimulus(OP_READ, 5'h0C, '0, '0, 0, 5);
        checkOutput("bp_rdata", lastRdata, 32'hCAFEF00D);

        // Zero strobe commits nothing but still answers OKAY
        applyStimulus(OP_WRITE, 5'h04, 32'hFFFFFFFF, 4'h0, 0, 0);
        checkOutput("strb0_bresp", lastBresp, 2'b00);
        checkOutput("strb0_reg1", regQ[63:32], 32'h00000002);

        // Same-cycle commit and read of one register returns the old value
        fork
            applyStimulus(OP_WRITE, 5'h04, 32'h12345678, 4'hF, 0, 0);
            applyStimulus(OP_READ, 5'h04, '0, '0, 0, 0);
        join
        checkOutput("same_cycle_old", lastRdata, 32'h00000002);
        applyStimulus(OP_READ, 5'h04, '0, '0, 0, 0);
        checkOutput("same_cycle_new", lastRdata, 32'h12345678);

        // Out-of-range address 0x10
        applyStimulus(OP_WRITE, 5'h10, 32'h00000055, 4'hF, 0, 0);
        applyStimulus(OP_READ, 5'h10, '0, '0, 0, 0);
`ifdef AXIL_REG_SLVERR_EN
        checkOutput("oor_bresp", lastBresp, 2'b10);
        checkOutput("oor_reg0", regQ[31:0], 32'hAA22CC44);
        checkOutput("oor_read", {lastRresp, lastRdata}, {2'b10, 32'h0});
`else
        checkOutput("alias_bresp", lastBresp, 2'b00);
        checkOutput("alias_reg0", regQ[31:0], 32'h00000055);
        checkOutput("alias_read", {lastRresp, lastRdata}, {2'b00, 32'h00000055});
`endif

        // Reset with both responses outstanding
        fork
            applyStimulus(OP_WRITE, 5'h04, 32'h0BADF00D, 4'hF, 0, -1);
            applyStimulus(OP_READ, 5'h08, '0, '0, 0, -1);
        join
        checkOutput("pending_both", {bus.bvalid, bus.rvalid}, 2'b11);
        areset = 1'b1;
        @(negedge clk);
        checkOutput("midrst_outputs", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
                                       bus.bresp, bus.rresp}, 9'b0);
        checkOutput("midrst_rdata", bus.rdata, 0);
        checkOutput("midrst_reg_q", regQ, 0);
        areset = 1'b0;
        @(negedge clk);
        checkOutput("midrst_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
        checkOutput("midrst_reg_q_after", regQ, 0);

        applyStimulus(OP_WRITE, 5'h0C, 32'h76543210, 4'hF, 0, 0);
        applyStimulus(OP_READ, 5'h0C, '0, '0, 0, 0);
        checkOutput("post_reset_rdata", lastRdata, 32'h76543210);

        repeat (2) @(negedge clk);
        checkOutput("b_queue_empty", bExpQ.size(), 0);
        checkOutput("r_queue_empty", rExpQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
